// File: rtl/param_updown_counter.sv
// Up/down counter over 0..MAX_VAL with wrap or saturate at the range ends, parallel load and status flags.
// Optional build macro PUC_EDGE_DETECT_EN: one step per rising edge of enable instead of one per clock while high.
module param_updown_counter #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             stepEn;

`ifdef PUC_EDGE_DETECT_EN
    logic enable_q;

    // Edge history keeps following enable through load cycles, so an edge seen during a load is used up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable;
        end
    end

    assign stepEn = enable & ~enable_q;
`else
    assign stepEn = enable;
`endif

    // Range-end compare happens before the +/-1, so a short range never relies on binary rollover.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        end else if (stepEn) begin
            if (up_down) begin
                if (count_q == MAX_VAL) begin
                    wrap_d = 1'b1;
                    if (!SATURATE) begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    wrap_d = 1'b1;
                    if (!SATURATE) begin
                        count_d = MAX_VAL;
                    end
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign at_max = (count_q == MAX_VAL);
    assign at_min = (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: three counter flavours (mod-16 wrap, mod-10 wrap, 0..9 saturate) share one stimulus stream
// and are compared every cycle against an arithmetic model, plus hand-computed spot checks.
module tb_param_updown_counter;

    localparam int MAXV [3] = '{15, 9, 9};
    localparam bit SATV [3] = '{1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       upDown;
    logic       load;
    logic [3:0] loadValue;

    logic [3:0] countA, countB, countC;
    logic       atMaxA, atMaxB, atMaxC;
    logic       atMinA, atMinB, atMinC;
    logic       wrapA, wrapB, wrapC;

    int passCount  = 0;
    int checkCount = 0;

    int mCount [3];
    bit mWrap  [3];
    bit mPrevEn;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4)) dutA (
        .clk(clk), .reset(reset), .enable(enable), .up_down(upDown), .load(load), .load_value(loadValue),
        .count(countA), .at_max(atMaxA), .at_min(atMinA), .wrap(wrapA)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) dutB (
        .clk(clk), .reset(reset), .enable(enable), .up_down(upDown), .load(load), .load_value(loadValue),
        .count(countB), .at_max(atMaxB), .at_min(atMinB), .wrap(wrapB)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) dutC (
        .clk(clk), .reset(reset), .enable(enable), .up_down(upDown), .load(load), .load_value(loadValue),
        .count(countC), .at_max(atMaxC), .at_min(atMinC), .wrap(wrapC)
    );

    // Next count from modular / clamped arithmetic over the range 0..maxv.
    function automatic int nextCount(int cur, int maxv, bit sat, bit qual, bit up, bit ld, int lv);
        if (ld) return (lv > maxv) ? maxv : lv;
        if (!qual) return cur;
        if (up) return sat ? ((cur + 1 > maxv) ? maxv : cur + 1) : (cur + 1) % (maxv + 1);
        return sat ? ((cur - 1 < 0) ? 0 : cur - 1) : (cur + maxv) % (maxv + 1);
    endfunction

    function automatic bit nextWrap(int cur, int maxv, bit qual, bit up, bit ld);
        if (ld || !qual) return 1'b0;
        return up ? (cur == maxv) : (cur == 0);
    endfunction

    // Reference model, advanced on the same edges as the counters.
    always @(posedge clk or posedge reset) begin
        bit qual;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                mCount[i] <= 0;
                mWrap[i]  <= 1'b0;
            end
            mPrevEn <= 1'b0;
        end else begin
`ifdef PUC_EDGE_DETECT_EN
            qual = enable & ~mPrevEn;
`else
            qual = enable;
`endif
            for (int i = 0; i < 3; i++) begin
                mCount[i] <= nextCount(mCount[i], MAXV[i], SATV[i], qual, upDown, load, int'(loadValue));
                mWrap[i]  <= nextWrap(mCount[i], MAXV[i], qual, upDown, load);
            end
            mPrevEn <= enable;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic checkInstance(input int i, input logic [3:0] c, input logic am, input logic an, input logic w);
        checkOutput($sformatf("model_count%0d", i), 32'(c), 32'(mCount[i]));
        checkOutput($sformatf("model_atMax%0d", i), 32'(am), 32'(mCount[i] == MAXV[i]));
        checkOutput($sformatf("model_atMin%0d", i), 32'(an), 32'(mCount[i] == 0));
        checkOutput($sformatf("model_wrap%0d", i), 32'(w), 32'(mWrap[i]));
    endtask

    // Outputs are sampled on the falling edge, half a period away from any update.
    always @(negedge clk) begin
        checkInstance(0, countA, atMaxA, atMinA, wrapA);
        checkInstance(1, countB, atMaxB, atMinB, wrapB);
        checkInstance(2, countC, atMaxC, atMinC, wrapC);
    end

    task automatic applyStimulus(input logic en, input logic ud, input logic ld, input logic [3:0] lv);
        enable    = en;
        upDown    = ud;
        load      = ld;
        loadValue = lv;
        @(negedge clk);
        #1;
    endtask

    // An idle cycle then an enable cycle gives exactly one step in either enable-qualification mode.
    task automatic stepOnce(input logic ud);
        applyStimulus(1'b0, ud, 1'b0, 4'd0);
        applyStimulus(1'b1, ud, 1'b0, 4'd0);
    endtask

    task automatic resetPulse();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        upDown    = 1'b0;
        load      = 1'b0;
        loadValue = 4'd0;
        #1 reset = 1'b1;
        #1;
        checkOutput("reset_count", 32'(countA), 32'd0);
        checkOutput("reset_atMin", 32'(atMinA), 32'd1);
        checkOutput("reset_wrap", 32'(wrapA), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;

        for (int k = 1; k <= 16; k++) begin
            stepOnce(1'b1);
            if (k == 15) begin
                checkOutput("up15_count", 32'(countA), 32'd15);
                checkOutput("up15_atMax", 32'(atMaxA), 32'd1);
                checkOutput("up15_wrap", 32'(wrapA), 32'd0);
            end
        end
        checkOutput("up16_count", 32'(countA), 32'd0);
        checkOutput("up16_wrap", 32'(wrapA), 32'd1);
        checkOutput("up16_mod10", 32'(countB), 32'd6);
        checkOutput("up16_sat", 32'(countC), 32'd9);
        checkOutput("up16_satWrap", 32'(wrapC), 32'd1);

        resetPulse();
        stepOnce(1'b0);
        checkOutput("down0_count", 32'(countB), 32'd9);
        checkOutput("down0_wrap", 32'(wrapB), 32'd1);
        checkOutput("down0_atMax", 32'(atMaxB), 32'd1);
        checkOutput("down0_satHold", 32'(countC), 32'd0);
        checkOutput("down0_satWrap", 32'(wrapC), 32'd1);
        for (int k = 0; k < 9; k++) stepOnce(1'b0);
        checkOutput("down9_count", 32'(countB), 32'd0);
        checkOutput("down9_atMin", 32'(atMinB), 32'd1);

        applyStimulus(1'b0, 1'b0, 1'b1, 4'd9);
        checkOutput("load9_count", 32'(countC), 32'd9);
        for (int k = 0; k < 3; k++) begin
            stepOnce(1'b1);
            checkOutput("satUp_count", 32'(countC), 32'd9);
            checkOutput("satUp_wrap", 32'(wrapC), 32'd1);
        end
        stepOnce(1'b0);
        checkOutput("satDown_count", 32'(countC), 32'd8);
        checkOutput("satDown_wrap", 32'(wrapC), 32'd0);

        applyStimulus(1'b1, 1'b1, 1'b1, 4'd12);
        checkOutput("clamp_count", 32'(countB), 32'd9);
        checkOutput("clamp_wrap", 32'(wrapB), 32'd0);
        checkOutput("load12_count", 32'(countA), 32'd12);

        resetPulse();
        for (int k = 0; k < 5; k++) stepOnce(1'b1);
        checkOutput("preAsync_count", 32'(countA), 32'd5);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncClear_count", 32'(countA), 32'd0);
        checkOutput("asyncClear_atMin", 32'(atMinA), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("resume_count", 32'(countA), 32'd1);

        resetPulse();
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
`ifdef PUC_EDGE_DETECT_EN
        checkOutput("hold10_count", 32'(countA), 32'd1);
`else
        checkOutput("hold10_count", 32'(countA), 32'd10);
`endif
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
            applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        end
`ifdef PUC_EDGE_DETECT_EN
        checkOutput("toggle3_count", 32'(countA), 32'd4);
`else
        checkOutput("toggle3_count", 32'(countA), 32'd13);
`endif

        resetPulse();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 80) == 0);
            applyStimulus(1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 99) < ((i < 300) ? 75 : 25)),
                          1'($urandom_range(0, 11) == 0),
                          4'($urandom_range(0, 15)));
        end
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's 4-bit enable counter. Counts up or down by one on each qualified enable, with a programmable modulus, wrap or saturate mode, synchronous parallel load, and status flags. Sits behind debounced button or strobe inputs, and drives display/FSM logic that needs a bounded count in either direction.

Parameters:
WIDTH, 4, counter width in bits (1..32)
MAX_VAL, 2**WIDTH-1, highest legal count; counting range is 0..MAX_VAL (MAX_VAL <= 2**WIDTH-1)
SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
enable  input  1  count request; level-qualified, or edge-qualified when the optional feature is compiled in
up_down  input  1  direction: 1 = up, 0 = down; sampled in the same cycle as the enable
load  input  1  synchronous parallel load strobe
load_value  input  WIDTH  value to load
count  output  WIDTH  registered counter value
at_max  output  1  combinational: count == MAX_VAL
at_min  output  1  combinational: count == 0
wrap  output  1  registered one-cycle pulse on the cycle after a wrap or saturation event

Behaviour:
- Reset (async, active-high): count=0, wrap=0, internal edge register=0. Outputs are valid immediately while reset is high. at_min=1 during reset.
- Priority per rising clk edge: reset > load > count step > hold.
- load=1: count <= min(load_value, MAX_VAL). The load ignores enable and up_down in that cycle. wrap <= 0.
- Qualified enable, up_down=1:
  - count < MAX_VAL: count <= count+1, wrap <= 0.
  - count == MAX_VAL, SATURATE=0: count <= 0, wrap <= 1.
  - count == MAX_VAL, SATURATE=1: count holds, wrap <= 1 (this is a saturation hit).
- Qualified enable, up_down=0:
  - count > 0: count <= count-1, wrap <= 0.
  - count == 0, SATURATE=0: count <= MAX_VAL, wrap <= 1.
  - count == 0, SATURATE=1: count holds, wrap <= 1.
- No qualified enable and no load: count holds, wrap <= 0. wrap is therefore never high for two cycles unless a range-end event occurs in consecutive cycles.
- Arithmetic is done in WIDTH bits; the range test against MAX_VAL prevents any binary overflow when MAX_VAL < 2**WIDTH-1.
- Latency: count updates on the edge that samples the request, so it is visible one cycle after enable. wrap is coincident with the updated count.
- Reset asserted mid-count: immediate clear, and any pending edge history is discarded.
- Out-of-range state is unreachable. Loads are clamped, so count is always <= MAX_VAL.

Optional Feature:
Macro PUC_EDGE_DETECT_EN.
- Defined: enable is registered internally (enable_d). A qualified enable is enable & ~enable_d, i.e. one step per rising edge of enable regardless of how long it is held. enable_d clears on reset. enable_d still tracks enable during load cycles, so an edge coincident with load is consumed and not replayed.
- Undefined: a qualified enable is enable itself, giving one step per clock while high. This matches the legacy counter. No edge register is synthesised.

Test Plan:
- WIDTH=4, default MAX_VAL, SATURATE=0: reset, then enable=1 up for 16 cycles -> count 1..15 then 0; wrap=1 only on the cycle count becomes 0.
- MAX_VAL=9, SATURATE=0, down from 0: one enable -> count=9, wrap=1, at_max=1. Nine more enables -> count=0, at_min=1.
- MAX_VAL=9, SATURATE=1: load 9, then enable up for 3 cycles -> count stays 9, wrap=1 each cycle. Down once -> count=8, wrap=0.
- load=1 with load_value=12, MAX_VAL=9, enable=1 in the same cycle -> count=9 (clamped, load wins), wrap=0.
- Count to 5, then assert reset asynchronously between clock edges -> count=0 immediately, before the next edge. Releasing reset with enable=1 -> counting resumes from 0.
- PUC_EDGE_DETECT_EN defined: hold enable high for 10 cycles -> count=1. Toggle enable 3 times -> count=4. With the macro undefined, the same 10-cycle hold -> count=10.
